// File: rtl/ps2_scan_ctrl.sv
// rtl/ps2_scan_ctrl.sv - PS/2 scan byte sequencer: prefix assembly, key state tracking, event queue
module ps2_scan_ctrl #(
    parameter int QDEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       ready,
    output logic       nextdata_n,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       key_down,
    output logic [7:0] held_code,
    output logic       shift,
    output logic       caps,
    output logic [7:0] press_cnt,
    output logic [7:0] err_cnt
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_POP, S_GAP} state_t;

    state_t      state_q, state_d;
    logic        nextdata_n_q, nextdata_n_d;
    logic [7:0]  byte_q, byte_d;
    logic        decode_en;
    logic        ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic        lshift_q, lshift_d, rshift_q, rshift_d;
    logic        caps_held_q, caps_held_d, caps_q, caps_d;
    logic        key_down_q, key_down_d, held_ext_q, held_ext_d;
    logic [7:0]  held_code_q, held_code_d;
    logic [7:0]  press_cnt_q, press_cnt_d, err_cnt_q, err_cnt_d;
    logic [9:0]  mem_q [QDEPTH];
    logic [9:0]  mem_d [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic q_full, start, push, pop, proto_err;
    logic is_lsh, is_rsh, is_caps, is_mod, mod_held, match_held;

    assign q_full = (cnt_q == CW'(QDEPTH));
    assign start  = ready && !q_full;
    assign pop    = (cnt_q != '0) && ev_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_POP;
            S_POP:   state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The pop strobe is a flop, so it is computed one cycle ahead of POP.
    always_comb begin
        nextdata_n_d = 1'b1;
        byte_d       = byte_q;
        decode_en    = 1'b0;
        if (state_q == S_IDLE && start) begin
            nextdata_n_d = 1'b0;
            byte_d       = data;
        end
        if (state_q == S_POP) decode_en = 1'b1;
    end

    always_comb begin
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_held_d = caps_held_q;
        caps_d      = caps_q;
        key_down_d  = key_down_q;
        held_ext_d  = held_ext_q;
        held_code_d = held_code_q;
        press_cnt_d = press_cnt_q;
        err_cnt_d   = err_cnt_q;
        push        = 1'b0;
        proto_err   = 1'b0;
        is_lsh      = !ext_pend_q && byte_q == 8'h12;
        is_rsh      = !ext_pend_q && byte_q == 8'h59;
        is_caps     = !ext_pend_q && byte_q == 8'h58;
        is_mod      = is_lsh || is_rsh || is_caps;
        mod_held    = (is_lsh && lshift_q) || (is_rsh && rshift_q) || (is_caps && caps_held_q);
        match_held  = key_down_q && held_code_q == byte_q && held_ext_q == ext_pend_q;
        if (decode_en) begin
            if (byte_q == 8'h00 || byte_q == 8'hFF) begin
                proto_err = 1'b1;
            end else if (byte_q == 8'hF0) begin
                if (brk_pend_q) proto_err = 1'b1;
                else            brk_pend_d = 1'b1;
            end else if (byte_q == 8'hE0) begin
                if (brk_pend_q || ext_pend_q) proto_err = 1'b1;
                else                          ext_pend_d = 1'b1;
            end else begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
                if (!brk_pend_q) begin
                    // Modifiers judge repeats by their own held bit, other keys by the held key.
                    if (!(is_mod ? mod_held : match_held)) begin
                        push        = 1'b1;
                        press_cnt_d = press_cnt_q + 8'd1;
                        if (is_lsh) lshift_d = 1'b1;
                        if (is_rsh) rshift_d = 1'b1;
                        if (is_caps) begin
                            caps_held_d = 1'b1;
                            caps_d      = !caps_q;
                        end
                        if (!is_mod) begin
                            key_down_d  = 1'b1;
                            held_code_d = byte_q;
                            held_ext_d  = ext_pend_q;
                        end
                    end
                end else begin
                    push = 1'b1;
                    if (is_lsh)  lshift_d    = 1'b0;
                    if (is_rsh)  rshift_d    = 1'b0;
                    if (is_caps) caps_held_d = 1'b0;
                    if (match_held) key_down_d = 1'b0;
                end
            end
            if (proto_err) begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // A push can never meet a full queue: pops from the receiver only start with space left.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {ext_pend_q, brk_pend_q, byte_q};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!push && pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nextdata_n_q <= 1'b1;
            byte_q       <= 8'h00;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            lshift_q     <= 1'b0;
            rshift_q     <= 1'b0;
            caps_held_q  <= 1'b0;
            caps_q       <= 1'b0;
            key_down_q   <= 1'b0;
            held_ext_q   <= 1'b0;
            held_code_q  <= 8'h00;
            press_cnt_q  <= 8'h00;
            err_cnt_q    <= 8'h00;
            for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            nextdata_n_q <= nextdata_n_d;
            byte_q       <= byte_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            lshift_q     <= lshift_d;
            rshift_q     <= rshift_d;
            caps_held_q  <= caps_held_d;
            caps_q       <= caps_d;
            key_down_q   <= key_down_d;
            held_ext_q   <= held_ext_d;
            held_code_q  <= held_code_d;
            press_cnt_q  <= press_cnt_d;
            err_cnt_q    <= err_cnt_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign nextdata_n = nextdata_n_q;
    assign ev_ext     = mem_q[rd_ptr_q][9];
    assign ev_break   = mem_q[rd_ptr_q][8];
    assign ev_code    = mem_q[rd_ptr_q][7:0];
    assign ev_valid   = (cnt_q != '0);
    assign key_down   = key_down_q;
    assign held_code  = held_code_q;
    assign shift      = lshift_q || rshift_q;
    assign caps       = caps_q;
    assign press_cnt  = press_cnt_q;
    assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// tb/tb_ps2_scan_ctrl.sv - directed and randomized bench for ps2_scan_ctrl with a behavioural key model
module tb_ps2_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready = 1'b0;
    logic       nextdata_n;
    logic [7:0] ev_code;
    logic       ev_ext, ev_break, ev_valid;
    logic       ev_ready = 1'b0;
    logic       key_down;
    logic [7:0] held_code;
    logic       shift, caps;
    logic [7:0] press_cnt, err_cnt;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int ev_seen = 0;

    logic [7:0] rxq [$];
    logic [9:0] expq [$];

    logic       m_ext, m_brk, m_lsh, m_rsh, m_caps_held, m_caps, m_kd, m_held_ext;
    logic [7:0] m_held;
    int         m_press, m_err;

    ps2_scan_ctrl #(.QDEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .ready(ready), .nextdata_n(nextdata_n),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .key_down(key_down), .held_code(held_code), .shift(shift),
        .caps(caps), .press_cnt(press_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0; m_caps_held = 0; m_caps = 0;
        m_kd = 0; m_held_ext = 0; m_held = 8'h00; m_press = 0; m_err = 0;
        expq.delete();
    endtask

    // Key-level model: what a keyboard user's actions mean, one received byte at a time.
    task automatic m_apply(input logic [7:0] b);
        logic e, k, mod, rep;
        if (b == 8'h00 || b == 8'hFF || (b == 8'hF0 && m_brk) || (b == 8'hE0 && (m_brk || m_ext))) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
            m_ext = 0; m_brk = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else begin
            e = m_ext; k = m_brk; m_ext = 0; m_brk = 0;
            mod = !e && (b == 8'h12 || b == 8'h59 || b == 8'h58);
            if (!k) begin
                if (mod) rep = (b == 8'h12) ? m_lsh : (b == 8'h59) ? m_rsh : m_caps_held;
                else     rep = m_kd && m_held == b && m_held_ext == e;
                if (!rep) begin
                    expq.push_back({e, k, b});
                    m_press = (m_press + 1) % 256;
                    if (mod) begin
                        if (b == 8'h12) m_lsh = 1;
                        if (b == 8'h59) m_rsh = 1;
                        if (b == 8'h58) begin m_caps_held = 1; m_caps = !m_caps; end
                    end else begin
                        m_kd = 1; m_held = b; m_held_ext = e;
                    end
                end
            end else begin
                expq.push_back({e, k, b});
                if (mod) begin
                    if (b == 8'h12) m_lsh = 0;
                    if (b == 8'h59) m_rsh = 0;
                    if (b == 8'h58) m_caps_held = 0;
                end else if (m_kd && m_held == b && m_held_ext == e) begin
                    m_kd = 0;
                end
            end
        end
    endtask

    // Receiver FIFO and event consumer, both acting away from the rising edge.
    always @(negedge clk) begin
        if (rst_n && !nextdata_n) begin
            pulses++;
            chk("pop_nonempty", rxq.size() != 0, 1);
            if (rxq.size() != 0) m_apply(rxq.pop_front());
        end
        if (rst_n && ev_valid && ev_ready) begin
            ev_seen++;
            chk("event_expected", expq.size() != 0, 1);
            if (expq.size() != 0) chk("event", {ev_ext, ev_break, ev_code}, expq.pop_front());
        end
        ready = (rxq.size() != 0);
        data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic settle(input int budget);
        int k = 0;
        while ((rxq.size() != 0 || expq.size() != 0 || nextdata_n !== 1'b1 || ev_valid !== 1'b0) && k < budget) begin
            cyc(1);
            k++;
        end
        chk("settle_in_time", k < budget, 1);
        cyc(3);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_press"}, press_cnt, m_press);
        chk({tag, "_err"}, err_cnt, m_err);
        chk({tag, "_shift"}, shift, m_lsh | m_rsh);
        chk({tag, "_caps"}, caps, m_caps);
        chk({tag, "_keydown"}, key_down, m_kd);
        chk({tag, "_held"}, held_code, m_held);
    endtask

    task automatic do_reset();
        rst_n = 0;
        m_reset();
        cyc(2);
        rst_n = 1;
        cyc(1);
    endtask

    task automatic wait_pop_neg(input string tag);
        int k = 0;
        @(negedge clk);
        while (nextdata_n !== 1'b0 && k < 30) begin @(negedge clk); k++; end
        chk(tag, k < 30, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pool [14];
        int p0, s0, k;
        pool = '{8'h1C, 8'h15, 8'h12, 8'h59, 8'h58, 8'h75, 8'hF0, 8'hF0, 8'hE0, 8'h00, 8'hFF, 8'h1C, 8'hF0, 8'hE0};
        m_reset();
        cyc(3);
        chk("rst_nextdata_n", nextdata_n, 1);
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_ev_word", {ev_ext, ev_break, ev_code}, 0);
        check_status("rst");
        rst_n = 1;
        cyc(2);

        // single make with exact timing
        pulses = 0;
        rxq.push_back(8'h1C);
        wait_pop_neg("t1_pop_seen");
        chk("t1_no_event_at_pop", ev_valid, 0);
        @(negedge clk);
        chk("t1_nextdata_high", nextdata_n, 1);
        chk("t1_ev_valid", ev_valid, 1);
        chk("t1_ev_word", {ev_ext, ev_break, ev_code}, {2'b00, 8'h1C});
        chk("t1_press", press_cnt, 1);
        chk("t1_keydown", key_down, 1);
        chk("t1_held", held_code, 8'h1C);
        cyc(1);
        ev_ready = 1;
        settle(100);
        chk("t1_one_pulse", pulses, 1);

        // make, repeat, break
        do_reset();
        s0 = ev_seen;
        foreach (pool[i]) ; // pool unused here
        rxq.push_back(8'h1C); rxq.push_back(8'h1C); rxq.push_back(8'h1C);
        rxq.push_back(8'hF0); rxq.push_back(8'h1C);
        settle(200);
        chk("t2_events", ev_seen - s0, 2);
        chk("t2_press", press_cnt, 1);
        chk("t2_keydown", key_down, 0);
        check_status("t2");

        // extended key and modifiers
        s0 = ev_seen;
        rxq.push_back(8'hE0); rxq.push_back(8'h75); rxq.push_back(8'hE0);
        rxq.push_back(8'hF0); rxq.push_back(8'h75);
        settle(200);
        chk("t3_ext_events", ev_seen - s0, 2);
        rxq.push_back(8'h12);
        settle(100);
        chk("t3_shift_on", shift, 1);
        rxq.push_back(8'h58); rxq.push_back(8'hF0); rxq.push_back(8'h58);
        rxq.push_back(8'hF0); rxq.push_back(8'h12);
        settle(200);
        chk("t3_shift_off", shift, 0);
        chk("t3_caps_on", caps, 1);
        check_status("t3a");
        rxq.push_back(8'h12); rxq.push_back(8'h58); rxq.push_back(8'hF0);
        rxq.push_back(8'h58); rxq.push_back(8'hF0); rxq.push_back(8'h12);
        settle(200);
        chk("t3_caps_off", caps, 0);
        check_status("t3b");

        // backpressure
        do_reset();
        ev_ready = 0;
        p0 = pulses;
        rxq.push_back(8'h15); rxq.push_back(8'h1D); rxq.push_back(8'h24);
        rxq.push_back(8'h2D); rxq.push_back(8'h2C);
        cyc(40);
        chk("t4_pops", pulses - p0, 4);
        chk("t4_left", rxq.size(), 1);
        chk("t4_stalled", nextdata_n, 1);
        chk("t4_head", ev_code, 8'h15);
        ev_ready = 1;
        cyc(1);
        ev_ready = 0;
        cyc(10);
        chk("t4_drained_rx", rxq.size(), 0);
        chk("t4_new_head", ev_code, 8'h1D);
        ev_ready = 1;
        settle(100);
        check_status("t4");

        // protocol errors
        rxq.push_back(8'hF0); rxq.push_back(8'hF0); rxq.push_back(8'h1C);
        settle(100);
        chk("t5_err1", err_cnt, 1);
        s0 = ev_seen;
        rxq.push_back(8'hFF);
        settle(100);
        chk("t5_err2", err_cnt, 2);
        chk("t5_no_event", ev_seen - s0, 0);
        for (int i = 0; i < 300; i++) rxq.push_back(8'hFF);
        settle(2000);
        chk("t5_err_sat", err_cnt, 255);
        check_status("t5");

        // reset during a pop, with an E0 prefix pending
        rxq.push_back(8'hE0);
        settle(100);
        ev_ready = 0;
        rxq.push_back(8'hF0);
        wait_pop_neg("t6_pop_seen");
        #1;
        rst_n = 0;
        #1;
        chk("t6_async_high", nextdata_n, 1);
        m_reset();
        cyc(2);
        chk("t6_ev_valid", ev_valid, 0);
        check_status("t6_rst");
        rst_n = 1;
        ev_ready = 1;
        cyc(1);
        rxq.push_back(8'h1C);
        settle(100);
        check_status("t6_after");

        // randomized byte streams with a stalling consumer
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 150; i++) rxq.push_back(pool[$urandom_range(0, 13)]);
            k = 0;
            while (rxq.size() != 0 && k < 5000) begin
                ev_ready = ($urandom_range(0, 2) != 0);
                cyc(1);
                k++;
            end
            chk("rnd_progress", k < 5000, 1);
            ev_ready = 1;
            settle(200);
            check_status("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
